// File: rtl/dual_slope_adc_seq.sv
// Dual-slope ADC sequencer: drives the integrator switches through reset, run-up and
// run-down, captures the run-down count, and is configured and read out over an SPI slave.
module dual_slope_adc_seq #(
    parameter int CNT_W     = 24,
    parameter int RESET_DEF = 100000,
    parameter int RUNUP_DEF = 1000000,
    parameter int TMO_DEF   = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic ssel,
    input  logic mosi,
    output logic miso,
    input  logic cmp,
    output logic m_reset,
    output logic m_in,
    output logic m_ref,
    output logic ref_pol,
    output logic busy,
    output logic data_valid,
    output logic err
);

    localparam logic [7:0] CMD_SINGLE = 8'hCC;
    localparam logic [7:0] CMD_CONT   = 8'hCD;
    localparam logic [7:0] CMD_STOP   = 8'hCE;
    localparam logic [7:0] CMD_WR_RST = 8'h10;
    localparam logic [7:0] CMD_WR_RUN = 8'h11;
    localparam logic [7:0] CMD_WR_TMO = 8'h12;

    localparam logic [5:0] CMD_BITS   = 6'd8;
    localparam logic [5:0] FRAME_BITS = 6'd40;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUNUP,
        ST_RUNDOWN
    } state_t;

    // Synchronisers: edges are taken between flop 2 and flop 3.
    logic [2:0] sck_ff;
    logic [2:0] ssel_ff;
    logic [2:0] cmp_ff;
    logic [1:0] mosi_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_ff  <= 3'b000;
            ssel_ff <= 3'b111;
            cmp_ff  <= 3'b000;
            mosi_ff <= 2'b00;
        end else begin
            sck_ff  <= {sck_ff[1:0], sck};
            ssel_ff <= {ssel_ff[1:0], ssel};
            cmp_ff  <= {cmp_ff[1:0], cmp};
            mosi_ff <= {mosi_ff[0], mosi};
        end
    end

    logic sck_rise, sck_fall, ssel_rise, ssel_fall, ssel_active;
    logic mosi_s, cmp_s, cmp_prev;

    assign sck_rise    = sck_ff[1] & ~sck_ff[2];
    assign sck_fall    = ~sck_ff[1] & sck_ff[2];
    assign ssel_rise   = ssel_ff[1] & ~ssel_ff[2];
    assign ssel_fall   = ~ssel_ff[1] & ssel_ff[2];
    assign ssel_active = ~ssel_ff[1];
    assign mosi_s      = mosi_ff[1];
    assign cmp_s       = cmp_ff[1];
    assign cmp_prev    = cmp_ff[2];

    // SPI shift registers. Only the low CNT_W data bits are kept, which is all any write uses.
    logic [5:0]       bit_cnt;
    logic [7:0]       cmd_sr;
    logic [CNT_W-1:0] data_sr;
    logic [39:0]      tx_sr;
    logic [39:0]      status_word;
    logic             continuous;
    logic [CNT_W-1:0] result;
    state_t           state;

    assign status_word = {data_valid, err, ref_pol, continuous, busy, 3'b000, 32'(result)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            cmd_sr  <= '0;
            data_sr <= '0;
            tx_sr   <= '0;
        end else if (ssel_fall) begin
            bit_cnt <= '0;
            tx_sr   <= status_word;
        end else if (ssel_active) begin
            if (sck_rise && bit_cnt != FRAME_BITS) begin
                bit_cnt <= bit_cnt + 6'd1;
                if (bit_cnt < CMD_BITS) begin
                    cmd_sr <= {cmd_sr[6:0], mosi_s};
                end else begin
                    data_sr <= {data_sr[CNT_W-2:0], mosi_s};
                end
            end
            if (sck_fall) begin
                tx_sr <= {tx_sr[38:0], 1'b0};
            end
        end
    end

    assign miso = tx_sr[39];

    // Frame decode happens only on the ssel rising edge.
    logic is_idle, has_cmd, full_frame;
    logic start_cmd, cont_on, cont_off, cfg_write, read_done;

    assign is_idle    = (state == ST_IDLE);
    assign has_cmd    = ssel_rise && (bit_cnt >= CMD_BITS);
    assign full_frame = ssel_rise && (bit_cnt == FRAME_BITS);
    assign start_cmd  = has_cmd && is_idle && (cmd_sr == CMD_SINGLE || cmd_sr == CMD_CONT);
    assign cont_on    = has_cmd && is_idle && (cmd_sr == CMD_CONT);
    assign cont_off   = has_cmd && (cmd_sr == CMD_STOP);
    assign cfg_write  = full_frame && is_idle;
    assign read_done  = full_frame;

    logic [CNT_W-1:0] reset_cnt, runup_cnt, tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_cnt  <= CNT_W'(RESET_DEF);
            runup_cnt  <= CNT_W'(RUNUP_DEF);
            tmo_cnt    <= CNT_W'(TMO_DEF);
            continuous <= 1'b0;
        end else begin
            if (cfg_write) begin
                case (cmd_sr)
                    CMD_WR_RST: reset_cnt <= data_sr;
                    CMD_WR_RUN: runup_cnt <= data_sr;
                    CMD_WR_TMO: tmo_cnt   <= data_sr;
                    default: ;
                endcase
            end
            if (cont_on) begin
                continuous <= 1'b1;
            end else if (cont_off) begin
                continuous <= 1'b0;
            end
        end
    end

    // Last cnt value of each phase; a programmed zero behaves as a length of one.
    logic [CNT_W-1:0] reset_last, runup_last, tmo_last;

    assign reset_last = (reset_cnt == '0) ? '0 : reset_cnt - ONE;
    assign runup_last = (runup_cnt == '0) ? '0 : runup_cnt - ONE;
    assign tmo_last   = (tmo_cnt == '0) ? '0 : tmo_cnt - ONE;

    state_t           state_n;
    logic [CNT_W-1:0] cnt, cnt_n, result_n;
    logic             m_reset_n, m_in_n, ref_pol_n, err_n, data_valid_n;
    logic             cmp_hit;

    // Run-down ends when the comparator crosses away from the polarity latched at run-up end.
    assign cmp_hit = (cmp_s != ref_pol) && (cmp_prev == ref_pol);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            m_reset    <= 1'b0;
            m_in       <= 1'b0;
            ref_pol    <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            m_reset    <= m_reset_n;
            m_in       <= m_in_n;
            ref_pol    <= ref_pol_n;
            result     <= result_n;
            err        <= err_n;
            data_valid <= data_valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        m_reset_n    = m_reset;
        m_in_n       = m_in;
        ref_pol_n    = ref_pol;
        result_n     = result;
        err_n        = err;
        data_valid_n = data_valid;

        // A completing conversion below overrides this clear.
        if (read_done) begin
            data_valid_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                m_reset_n = 1'b0;
                m_in_n    = 1'b0;
                cnt_n     = '0;
                if (start_cmd || continuous) begin
                    state_n = ST_RESET;
                end
            end
            ST_RESET: begin
                if (cnt == reset_last) begin
                    m_reset_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = ST_RUNUP;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            ST_RUNUP: begin
                if (cnt == runup_last) begin
                    ref_pol_n = cmp_s;
                    m_in_n    = 1'b1;
                    cnt_n     = '0;
                    state_n   = ST_RUNDOWN;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            ST_RUNDOWN: begin
                if (cmp_hit) begin
                    result_n     = cnt + ONE;
                    err_n        = 1'b0;
                    data_valid_n = 1'b1;
                    m_reset_n    = 1'b0;
                    m_in_n       = 1'b0;
                    cnt_n        = '0;
                    state_n      = ST_IDLE;
                end else if (cnt == tmo_last) begin
                    result_n     = '1;
                    err_n        = 1'b1;
                    data_valid_n = 1'b1;
                    m_reset_n    = 1'b0;
                    m_in_n       = 1'b0;
                    cnt_n        = '0;
                    state_n      = ST_IDLE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign m_ref = ~m_in;

endmodule

// File: tb/tb_dual_slope_adc_seq.sv
// Bench for dual_slope_adc_seq: table of single conversions plus hand-written sequences
// for continuous mode, protocol robustness and asynchronous reset.
module tb_dual_slope_adc_seq;

    localparam int CNT_W     = 24;
    localparam int RESET_DEF = 6;
    localparam int RUNUP_DEF = 30;
    localparam int TMO_DEF   = 40;

    logic clk, rst_n, sck, ssel, mosi, cmp;
    logic miso, m_reset, m_in, m_ref, ref_pol, busy, data_valid, err;

    logic cmp_man, osc_en, osc_val;
    int   osc_ph;
    assign cmp = osc_en ? osc_val : cmp_man;

    int          checks = 0;
    int          failures = 0;
    logic [39:0] rx;

    typedef struct {
        int          rcnt;
        int          ucnt;
        int          tcnt;
        logic        cmp_lvl;
        int          tog;
        int          exp_rl;
        int          exp_ul;
        int          exp_dl;
        logic [7:0]  exp_status;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[6];

    dual_slope_adc_seq #(
        .CNT_W(CNT_W),
        .RESET_DEF(RESET_DEF),
        .RUNUP_DEF(RUNUP_DEF),
        .TMO_DEF(TMO_DEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sck(sck),
        .ssel(ssel),
        .mosi(mosi),
        .miso(miso),
        .cmp(cmp),
        .m_reset(m_reset),
        .m_in(m_in),
        .m_ref(m_ref),
        .ref_pol(ref_pol),
        .busy(busy),
        .data_valid(data_valid),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running comparator stimulus for continuous mode.
    initial begin
        osc_val = 1'b0;
        osc_ph  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (osc_en) begin
                osc_ph++;
                if (osc_ph >= 7) begin
                    osc_val = ~osc_val;
                    osc_ph  = 0;
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return busy;
            1:       return m_reset;
            default: return m_in;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic val, input int bound, input string name);
        int n = 0;
        while (sig_sel(sel) !== val && n < bound) begin
            tick(1);
            n++;
        end
        check(name, 64'(sig_sel(sel)), 64'(val));
    endtask

    // Mode-0 master: 8 clk per half period, miso sampled just before each rising edge.
    task automatic spi_xfer(input int nbits, input logic [39:0] frame, output logic [39:0] rd);
        rd   = '0;
        ssel = 1'b0;
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[39-i];
            tick(8);
            rd  = {rd[38:0], miso};
            sck = 1'b1;
            tick(8);
            sck = 1'b0;
        end
        tick(8);
        ssel = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic spi_write(input logic [7:0] c, input int val);
        logic [39:0] rd;
        spi_xfer(40, {c, 32'(val)}, rd);
        tick(8);
    endtask

    task automatic do_conv(input string tag, input vec_t v, input bit wr);
        logic [39:0] rd;
        int rl = 0;
        int ul = 0;
        int dl = 0;
        cmp_man = v.cmp_lvl;
        if (wr) begin
            spi_write(8'h10, v.rcnt);
            spi_write(8'h11, v.ucnt);
            spi_write(8'h12, v.tcnt);
        end
        tick(8);
        spi_xfer(8, {8'hCC, 32'h0}, rd);
        wait_sig(0, 1'b1, 40, {tag, "_start"});
        while (busy && !m_reset && rl < 5000) begin
            rl++;
            tick(1);
        end
        check({tag, "_reset_len"}, 64'(rl), 64'(v.exp_rl));
        while (m_reset && !m_in && ul < 5000) begin
            ul++;
            tick(1);
        end
        check({tag, "_runup_len"}, 64'(ul), 64'(v.exp_ul));
        while (m_in && dl < 5000) begin
            if (dl == v.tog) cmp_man = ~cmp_man;
            dl++;
            tick(1);
        end
        check({tag, "_rundown_len"}, 64'(dl), 64'(v.exp_dl));
        check({tag, "_flags"}, 64'({busy, data_valid, err}), 64'({1'b0, 1'b1, v.exp_status[6]}));
        spi_xfer(40, 40'h0, rd);
        tick(8);
        check({tag, "_readout"}, 64'(rd), 64'({v.exp_status, v.exp_result}));
        check({tag, "_dv_clear"}, 64'(data_valid), 64'(0));
    endtask

    initial begin
        vec_t v;
        int   g;
        int   nb;
        logic dv_at_gap, err_at_gap;

        // rcnt ucnt tcnt cmp tog | reset runup rundown status result
        // A toggle at rundown cycle k is seen 3 cycles later, so the result is k+3.
        vecs[0] = '{4, 20, 100, 1'b0, 37, 4, 20, 40, 8'h80, 32'd40};
        vecs[1] = '{4, 20, 100, 1'b1, 10, 4, 20, 13, 8'hA0, 32'd13};
        vecs[2] = '{4, 20, 50,  1'b0, -1, 4, 20, 50, 8'hC0, 32'h00FF_FFFF};
        vecs[3] = '{0, 0,  0,   1'b0, -1, 1, 1,  1,  8'hC0, 32'h00FF_FFFF};
        vecs[4] = '{3, 5,  8,   1'b1, 5,  3, 5,  8,  8'hA0, 32'd8};
        vecs[5] = '{3, 5,  8,   1'b0, 6,  3, 5,  8,  8'hC0, 32'h00FF_FFFF};

        rst_n   = 1'b0;
        sck     = 1'b0;
        ssel    = 1'b1;
        mosi    = 1'b0;
        cmp_man = 1'b0;
        osc_en  = 1'b0;
        tick(3);
        check("reset_outputs", 64'({m_reset, m_in, m_ref, ref_pol, busy, data_valid, err, miso}),
              64'(8'b0010_0000));
        rst_n = 1'b1;
        tick(3);
        spi_xfer(40, 40'h0, rx);
        tick(8);
        check("reset_readout", 64'(rx), 64'(0));

        for (int i = 0; i < 6; i++) begin
            do_conv($sformatf("vec%0d", i), vecs[i], 1'b1);
        end

        // Continuous mode with a toggling comparator.
        spi_write(8'h10, 4);
        spi_write(8'h11, 300);
        spi_write(8'h12, 50);
        osc_en = 1'b1;
        spi_xfer(8, {8'hCD, 32'h0}, rx);
        wait_sig(0, 1'b1, 40, "cont_start");
        for (int k = 0; k < 2; k++) begin
            wait_sig(0, 1'b0, 1000, $sformatf("cont_done%0d", k));
            dv_at_gap  = data_valid;
            err_at_gap = err;
            g = 0;
            while (!busy && g < 100) begin
                g++;
                tick(1);
            end
            check($sformatf("cont_gap%0d", k), 64'(g), 64'(1));
            check($sformatf("cont_dv%0d", k), 64'(dv_at_gap), 64'(1));
            check($sformatf("cont_err%0d", k), 64'(err_at_gap), 64'(0));
        end
        wait_sig(1, 1'b1, 20, "cont_runup_entry");
        spi_xfer(8, {8'hCE, 32'h0}, rx);
        check("stop_mid_runup", 64'({m_reset, m_in}), 64'(2'b10));
        wait_sig(0, 1'b0, 1000, "stop_conv_done");
        nb = 0;
        for (int k = 0; k < 50; k++) begin
            if (busy) nb++;
            tick(1);
        end
        check("stop_stays_idle", 64'(nb), 64'(0));
        osc_en  = 1'b0;
        cmp_man = 1'b0;
        spi_xfer(40, 40'h0, rx);
        tick(8);
        check("stop_status", 64'({rx[39:38], rx[36:32]}), 64'(7'b10_00000));
        check("stop_result_range", 64'(rx[31:0] >= 32'd1 && rx[31:0] <= 32'd20), 64'(1));

        // Writes and starts while busy, short frames.
        spi_write(8'h11, 1000);
        cmp_man = 1'b0;
        spi_xfer(8, {8'hCC, 32'h0}, rx);
        tick(8);
        check("busy_after_start", 64'(busy), 64'(1));
        spi_write(8'h11, 10);
        spi_xfer(8, {8'hCC, 32'h0}, rx);
        tick(8);
        wait_sig(0, 1'b0, 2000, "busy_conv_done");
        nb = 0;
        for (int k = 0; k < 30; k++) begin
            if (busy) nb++;
            tick(1);
        end
        check("start_while_busy_ignored", 64'(nb), 64'(0));
        spi_xfer(39, {8'h12, 32'd10}, rx);
        tick(8);
        spi_xfer(5, {8'hCC, 32'h0}, rx);
        tick(8);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) nb++;
            tick(1);
        end
        check("short_frame_no_start", 64'(nb), 64'(0));
        check("short_frame_dv_kept", 64'(data_valid), 64'(1));
        v = '{0, 0, 0, 1'b0, -1, 4, 1000, 50, 8'hC0, 32'h00FF_FFFF};
        do_conv("robust", v, 1'b0);

        // Asynchronous reset in the middle of run-down.
        cmp_man = 1'b1;
        spi_xfer(8, {8'hCC, 32'h0}, rx);
        wait_sig(2, 1'b1, 1200, "arst_rundown_entry");
        tick(5);
        check("arst_pre_refpol", 64'(ref_pol), 64'(1));
        rst_n = 1'b0;
        #2;
        check("arst_outputs", 64'({m_reset, m_in, m_ref, ref_pol, busy, data_valid, err, miso}),
              64'(8'b0010_0000));
        tick(3);
        rst_n = 1'b1;
        tick(3);
        spi_xfer(40, 40'h0, rx);
        tick(8);
        check("arst_readout", 64'(rx), 64'(0));
        v = '{0, 0, 0, 1'b0, -1, RESET_DEF, RUNUP_DEF, TMO_DEF, 8'hC0, 32'h00FF_FFFF};
        do_conv("defaults", v, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
